counter_seq_ctrl: RTL

- Sequencer for a loadable free-running counter (next = load ? load_data : count+1 mod 2^WIDTH; no enable input).
- Drives the counter's load/load_data pins to preset it, freeze it (reload current value) and reload it at a programmed terminal value.
- Provides one-shot and auto-reload interval timing with start/stop/pause control, a done pulse and a completed-period count.

---
 rtl/counter_seq_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external loadable free-running counter: preset, freeze, terminal reload,
// one-shot/auto-reload timing with pause. Optional sticky irq under COUNTER_SEQ_CTRL_IRQ_EN.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             mode,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_data,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] periods
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   start_q, end_q;
  logic               mode_q;
  logic               done_q;
  logic [PER_W-1:0]   periods_q;
  logic               accept;
  logic               hit;
  logic               terminal;

  assign terminal = (cnt_count == end_q);

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= '0;
      end_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      periods_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= hit;
      if (accept) begin
        start_q   <= start_val;
        end_q     <= end_val;
        mode_q    <= mode;
        periods_q <= '0;
      end else if (hit && (periods_q != '1)) begin
        periods_q <= periods_q + PER_W'(1);
      end
    end
  end

  // Next-state logic; RUN priority is stop > terminal > pause
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (terminal) begin
          hit = 1'b1;
          if (!mode_q) state_d = IDLE;
        end else if (pause) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop)        state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter control: default is freeze (reload the current value)
  always_comb begin
    cnt_load      = 1'b1;
    cnt_load_data = cnt_count;
    if (!reset) begin
      unique case (state_q)
        IDLE: ;
        LOAD: cnt_load_data = start_q;
        RUN: begin
          if (!stop) begin
            if (terminal) begin
              if (mode_q) cnt_load_data = start_q;
            end else if (!pause) begin
              cnt_load = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stop && !pause) cnt_load = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign periods = periods_q;

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  logic irq_q;

  // Set from the registered done pulse so a coincident clear loses
  always_ff @(posedge clk) begin
    if (reset)         irq_q <= 1'b0;
    else if (done_q)   irq_q <= 1'b1;
    else if (irq_clr)  irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

endmodule
